// File: rtl/bullet_oam_writer_pkg.sv
// Shared types for the bullet OAM: entry layout, directions, writer FSM states.
// The entry packing here is also read by bullet_engine.
package bullet_pkg;

   localparam int OAM_W        = 32;
   localparam int OAM_DIR_LSB  = 29;
   localparam int OAM_ACT_BIT  = 28;
   localparam int OAM_X_LSB    = 18;
   localparam int OAM_Y_LSB    = 8;
   localparam int OAM_OWN_LSB  = 6;
   localparam int OAM_TILE_LSB = 0;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_RIGHT = 2'b01,
      DIR_DOWN  = 2'b10,
      DIR_LEFT  = 2'b11
   } dir_e;

   typedef struct packed {
      logic       rsvd;
      dir_e       dir;
      logic       active;
      logic [9:0] x;
      logic [9:0] y;
      logic [1:0] owner;
      logic [5:0] tile;
   } oam_entry_t;

   typedef struct packed {
      dir_e       dir;
      logic [9:0] x;
      logic [9:0] y;
      logic [1:0] owner;
   } slot_t;

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_SPAWN,
      ST_SWEEP
   } wr_state_e;

   function automatic oam_entry_t make_entry(input dir_e dir, input logic [9:0] x,
                                             input logic [9:0] y, input logic [1:0] owner,
                                             input logic [5:0] tile);
      logic [OAM_W-1:0] w;
      w = '0;
      w[OAM_DIR_LSB +: 2]  = dir;
      w[OAM_ACT_BIT]       = 1'b1;
      w[OAM_X_LSB +: 10]   = x;
      w[OAM_Y_LSB +: 10]   = y;
      w[OAM_OWN_LSB +: 2]  = owner;
      w[OAM_TILE_LSB +: 6] = tile;
      return oam_entry_t'(w);
   endfunction

endpackage

// File: rtl/bullet_oam_writer_if.sv
// Fire/hit request side and OAM write port of the bullet OAM writer.
// master = the writer, slave = the surrounding game logic / OAM storage.
interface bullet_oam_writer_if #(parameter int N_SLOTS = 8) ();
   import bullet_pkg::*;

   localparam int AW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

   logic             frame_tick;
   logic             fire_valid;
   logic             fire_ready;
   logic [9:0]       fire_x;
   logic [9:0]       fire_y;
   logic [1:0]       fire_dir;
   logic [1:0]       fire_owner;
   logic             hit_valid;
   logic [AW-1:0]    hit_slot;
   logic             oam_we;
   logic [AW-1:0]    oam_waddr;
   logic [OAM_W-1:0] oam_wdata;

   modport master (
      input  frame_tick, fire_valid, fire_x, fire_y, fire_dir, fire_owner,
             hit_valid, hit_slot,
      output fire_ready, oam_we, oam_waddr, oam_wdata
   );

   modport slave (
      output frame_tick, fire_valid, fire_x, fire_y, fire_dir, fire_owner,
             hit_valid, hit_slot,
      input  fire_ready, oam_we, oam_waddr, oam_wdata
   );

endinterface

// File: rtl/bullet_oam_writer_step.sv
// Per-frame motion of one bullet: next x/y and an off-screen retire flag.
// With BULLET_WRAP_EN defined, coordinates wrap around the screen instead of retiring.
module bullet_step
   import bullet_pkg::*;
#(
   parameter int SPEED       = 4,
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int BULLET_SIZE = 8
) (
   input  logic [9:0] i_x,
   input  logic [9:0] i_y,
   input  dir_e       i_dir,
   output logic [9:0] o_x,
   output logic [9:0] o_y,
   output logic       o_retire
);

   localparam logic [10:0] SPD = 11'(SPEED);
`ifdef BULLET_WRAP_EN
   localparam logic [10:0] W_LIM = 11'(SCREEN_W);
   localparam logic [10:0] H_LIM = 11'(SCREEN_H);
`else
   localparam logic [10:0] X_MAX = 11'(SCREEN_W - BULLET_SIZE);
   localparam logic [10:0] Y_MAX = 11'(SCREEN_H - BULLET_SIZE);
`endif

   logic [10:0] w_x;
   logic [10:0] w_y;

   assign w_x = {1'b0, i_x};
   assign w_y = {1'b0, i_y};

   always_comb begin
      o_x      = i_x;
      o_y      = i_y;
      o_retire = 1'b0;
      unique case (i_dir)
`ifdef BULLET_WRAP_EN
         DIR_UP:    o_y = (w_y < SPD) ? 10'(w_y + H_LIM - SPD) : 10'(w_y - SPD);
         DIR_DOWN:  o_y = ((w_y + SPD) >= H_LIM) ? 10'(w_y + SPD - H_LIM) : 10'(w_y + SPD);
         DIR_LEFT:  o_x = (w_x < SPD) ? 10'(w_x + W_LIM - SPD) : 10'(w_x - SPD);
         DIR_RIGHT: o_x = ((w_x + SPD) >= W_LIM) ? 10'(w_x + SPD - W_LIM) : 10'(w_x + SPD);
`else
         DIR_UP:    if (w_y < SPD) o_retire = 1'b1; else o_y = 10'(w_y - SPD);
         DIR_DOWN:  if ((w_y + SPD) > Y_MAX) o_retire = 1'b1; else o_y = 10'(w_y + SPD);
         DIR_LEFT:  if (w_x < SPD) o_retire = 1'b1; else o_x = 10'(w_x - SPD);
         DIR_RIGHT: if ((w_x + SPD) > X_MAX) o_retire = 1'b1; else o_x = 10'(w_x + SPD);
`endif
         default:   o_retire = 1'b0;
      endcase
   end

endmodule

// File: rtl/bullet_oam_writer.sv
// Write-side owner of the bullet OAM: clears, spawns, sweeps and retires bullet slots.
// Edge behaviour selected by BULLET_WRAP_EN (see bullet_step).
module bullet_oam_writer
   import bullet_pkg::*;
#(
   parameter int         N_SLOTS     = 8,
   parameter int         SPEED       = 4,
   parameter int         SCREEN_W    = 640,
   parameter int         SCREEN_H    = 480,
   parameter int         BULLET_SIZE = 8,
   parameter logic [5:0] TILE_IDX    = 6'b000_001
) (
   input  logic                 clk,
   input  logic                 rst_n,
   bullet_oam_writer_if.master  bus,
   output logic [N_SLOTS-1:0]   active_mask,
   output logic                 busy,
   output logic                 tick_overrun
);

   localparam int AW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

   wr_state_e          r_state, w_state_nxt;
   logic [AW-1:0]      r_idx, w_idx_nxt;
   logic [N_SLOTS-1:0] r_mask, w_mask_nxt;
   logic [N_SLOTS-1:0] r_kill, w_kill_nxt;
   slot_t              r_slot [N_SLOTS];
   logic               r_we, w_we;
   logic [AW-1:0]      r_waddr, w_waddr;
   logic [OAM_W-1:0]   r_wdata, w_wdata;
   logic               r_overrun;

   logic               w_sh_we;
   logic [AW-1:0]      w_sh_idx;
   slot_t              w_sh_val;
   slot_t              w_cur;
   logic [9:0]         w_nx, w_ny;
   logic               w_retire;
   logic [AW-1:0]      w_free_idx, w_kill_idx;
   logic               w_free_found, w_kill_any;
   logic               w_fire_rdy, w_hit_live, w_hit_cur;

   assign w_cur      = r_slot[r_idx];
   assign w_hit_live = bus.hit_valid && r_mask[bus.hit_slot];
   assign w_hit_cur  = bus.hit_valid && (bus.hit_slot == r_idx);

   bullet_step #(
      .SPEED       (SPEED),
      .SCREEN_W    (SCREEN_W),
      .SCREEN_H    (SCREEN_H),
      .BULLET_SIZE (BULLET_SIZE)
   ) u_step (
      .i_x      (w_cur.x),
      .i_y      (w_cur.y),
      .i_dir    (w_cur.dir),
      .o_x      (w_nx),
      .o_y      (w_ny),
      .o_retire (w_retire)
   );

   always_comb begin
      w_free_idx   = '0;
      w_free_found = 1'b0;
      w_kill_idx   = '0;
      w_kill_any   = 1'b0;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
         if (!r_mask[i] && !w_free_found) begin
            w_free_idx   = AW'(i);
            w_free_found = 1'b1;
         end
         if (r_kill[i] && !w_kill_any) begin
            w_kill_idx = AW'(i);
            w_kill_any = 1'b1;
         end
      end
   end

   // A hit marks the slot dead at once and queues its zero write; a sweep or
   // the IDLE kill service later drains the queue, so no hit is ever lost.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_mask_nxt  = r_mask;
      w_kill_nxt  = r_kill;
      w_we        = 1'b0;
      w_waddr     = r_idx;
      w_wdata     = '0;
      w_sh_we     = 1'b0;
      w_sh_idx    = r_idx;
      w_sh_val    = '{dir: w_cur.dir, x: w_nx, y: w_ny, owner: w_cur.owner};
      w_fire_rdy  = 1'b0;

      if (r_state != ST_CLEAR && w_hit_live) begin
         w_mask_nxt[bus.hit_slot] = 1'b0;
         w_kill_nxt[bus.hit_slot] = 1'b1;
      end

      unique case (r_state)
         ST_CLEAR: begin
            w_we = 1'b1;
            if (r_idx == AW'(N_SLOTS - 1)) begin
               w_state_nxt = ST_IDLE;
               w_idx_nxt   = '0;
            end else begin
               w_idx_nxt = r_idx + 1'b1;
            end
         end
         ST_IDLE: begin
            w_fire_rdy = !bus.frame_tick && !(&r_mask) && !w_kill_any;
            if (bus.frame_tick) begin
               w_state_nxt = ST_SWEEP;
               w_idx_nxt   = '0;
            end else if (w_kill_any) begin
               w_we                   = 1'b1;
               w_waddr                = w_kill_idx;
               w_kill_nxt[w_kill_idx] = 1'b0;
            end else if (bus.fire_valid && w_fire_rdy) begin
               w_we                   = 1'b1;
               w_waddr                = w_free_idx;
               w_wdata                = make_entry(dir_e'(bus.fire_dir), bus.fire_x, bus.fire_y,
                                                   bus.fire_owner, TILE_IDX);
               w_mask_nxt[w_free_idx] = 1'b1;
               w_sh_we                = 1'b1;
               w_sh_idx               = w_free_idx;
               w_sh_val               = '{dir: dir_e'(bus.fire_dir), x: bus.fire_x,
                                          y: bus.fire_y, owner: bus.fire_owner};
               w_state_nxt            = ST_SPAWN;
            end
         end
         ST_SPAWN: w_state_nxt = ST_IDLE;
         ST_SWEEP: begin
            w_we              = 1'b1;
            w_kill_nxt[r_idx] = 1'b0;
            if (r_mask[r_idx] && !w_hit_cur && !w_retire) begin
               w_wdata = make_entry(w_cur.dir, w_nx, w_ny, w_cur.owner, TILE_IDX);
               w_sh_we = 1'b1;
            end else begin
               w_mask_nxt[r_idx] = 1'b0;
            end
            if (r_idx == AW'(N_SLOTS - 1)) begin
               w_state_nxt = ST_IDLE;
               w_idx_nxt   = '0;
            end else begin
               w_idx_nxt = r_idx + 1'b1;
            end
         end
         default: w_state_nxt = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_CLEAR;
         r_idx     <= '0;
         r_mask    <= '0;
         r_kill    <= '0;
         r_we      <= 1'b0;
         r_waddr   <= '0;
         r_wdata   <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_mask    <= w_mask_nxt;
         r_kill    <= w_kill_nxt;
         r_we      <= w_we;
         r_waddr   <= w_waddr;
         r_wdata   <= w_wdata;
         r_overrun <= r_overrun |
                      (bus.frame_tick && r_state != ST_IDLE && r_state != ST_CLEAR);
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && w_sh_we) r_slot[w_sh_idx] <= w_sh_val;
   end

   assign bus.fire_ready = w_fire_rdy;
   assign bus.oam_we     = r_we;
   assign bus.oam_waddr  = r_waddr;
   assign bus.oam_wdata  = r_wdata;
   assign active_mask    = r_mask;
   assign busy           = (r_state != ST_IDLE);
   assign tick_overrun   = r_overrun;

endmodule

// File: tb/tb_bullet_oam_writer.sv
// Directed bench for bullet_oam_writer: clear, spawn, sweep, retire, kill and overrun cases.
module tb_bullet_oam_writer;

   localparam int N = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] active_mask;
   logic       busy;
   logic       tick_overrun;

   always #5 clk = ~clk;

   bullet_oam_writer_if #(.N_SLOTS(N)) bus ();

   bullet_oam_writer #(
      .N_SLOTS     (N),
      .SPEED       (4),
      .SCREEN_W    (640),
      .SCREEN_H    (480),
      .BULLET_SIZE (8),
      .TILE_IDX    (6'b000_001)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .active_mask  (active_mask),
      .busy         (busy),
      .tick_overrun (tick_overrun)
   );

   int         n_vec = 0;
   int         n_mis = 0;
   int         tx [N];
   int         ty [N];
   int         td [N];
   int         tow [N];
   logic [7:0] exp_mask;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ent(input int d, input int x, input int y, input int o);
      return {1'b0, 2'(d), 1'b1, 10'(x), 10'(y), 2'(o), 6'b000001};
   endfunction

   function automatic void model_step(input int d, input int x, input int y,
                                      output int nx, output int ny, output bit ret);
      nx = x; ny = y; ret = 1'b0;
`ifdef BULLET_WRAP_EN
      case (d)
         0: ny = (y + 480 - 4) % 480;
         1: nx = (x + 4) % 640;
         2: ny = (y + 4) % 480;
         default: nx = (x + 640 - 4) % 640;
      endcase
`else
      case (d)
         0: if (y < 4) ret = 1'b1; else ny = y - 4;
         1: if (x + 4 > 632) ret = 1'b1; else nx = x + 4;
         2: if (y + 4 > 472) ret = 1'b1; else ny = y + 4;
         default: if (x < 4) ret = 1'b1; else nx = x - 4;
      endcase
`endif
   endfunction

   task automatic clear_check();
      for (int i = 0; i < N; i++) begin
         step();
         check_eq("clr_we", bus.oam_we, 1);
         check_eq("clr_addr", bus.oam_waddr, i);
         check_eq("clr_data", bus.oam_wdata, 0);
      end
      check_eq("clr_busy", busy, 0);
      check_eq("clr_ready", bus.fire_ready, 1);
      check_eq("clr_mask", active_mask, 0);
      exp_mask = '0;
   endtask

   task automatic fire(input int x, input int y, input int d, input int o, input int slot);
      bus.fire_valid = 1'b1;
      bus.fire_x     = 10'(x);
      bus.fire_y     = 10'(y);
      bus.fire_dir   = 2'(d);
      bus.fire_owner = 2'(o);
      step();
      bus.fire_valid = 1'b0;
      exp_mask[slot] = 1'b1;
      tx[slot] = x; ty[slot] = y; td[slot] = d; tow[slot] = o;
      check_eq("fire_we", bus.oam_we, 1);
      check_eq("fire_addr", bus.oam_waddr, slot);
      check_eq("fire_data", bus.oam_wdata, ent(d, x, y, o));
      check_eq("fire_mask", active_mask, exp_mask);
      step();
   endtask

   // Slot i is evaluated in the cycle after the i-th post-tick edge; hit/tick
   // stimulus for slot i is driven just before that edge.
   task automatic sweep(input int hit_at, input int tick_at);
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      check_eq("sweep_start_we", bus.oam_we, 0);
      check_eq("sweep_busy", busy, 1);
      for (int i = 0; i < N; i++) begin
         logic [31:0] e;
         int          nx, ny;
         bit          r;
         if (i == hit_at) begin
            bus.hit_valid = 1'b1;
            bus.hit_slot  = 3'(i);
         end
         if (i == tick_at) bus.frame_tick = 1'b1;
         step();
         bus.hit_valid  = 1'b0;
         bus.frame_tick = 1'b0;
         e = '0;
         if (exp_mask[i] && i != hit_at) begin
            model_step(td[i], tx[i], ty[i], nx, ny, r);
            if (!r) begin
               tx[i] = nx;
               ty[i] = ny;
               e = ent(td[i], nx, ny, tow[i]);
            end
         end
         if (e == 0) exp_mask[i] = 1'b0;
         check_eq("sweep_we", bus.oam_we, 1);
         check_eq("sweep_addr", bus.oam_waddr, i);
         check_eq("sweep_data", bus.oam_wdata, e);
      end
      check_eq("sweep_mask", active_mask, exp_mask);
      check_eq("sweep_done_busy", busy, 0);
   endtask

   initial begin
      bus.frame_tick = 1'b0;
      bus.fire_valid = 1'b0;
      bus.fire_x     = '0;
      bus.fire_y     = '0;
      bus.fire_dir   = '0;
      bus.fire_owner = '0;
      bus.hit_valid  = 1'b0;
      bus.hit_slot   = '0;
      exp_mask       = '0;

      repeat (3) step();
      check_eq("rst_we", bus.oam_we, 0);
      check_eq("rst_addr", bus.oam_waddr, 0);
      check_eq("rst_data", bus.oam_wdata, 0);
      check_eq("rst_mask", active_mask, 0);
      check_eq("rst_overrun", tick_overrun, 0);
      check_eq("rst_ready", bus.fire_ready, 0);
      check_eq("rst_busy", busy, 1);

      rst_n = 1'b1;
      clear_check();

      // First spawn checked against the hand-packed entry.
      bus.fire_valid = 1'b1;
      bus.fire_x     = 10'd100;
      bus.fire_y     = 10'd100;
      bus.fire_dir   = 2'b01;
      bus.fire_owner = 2'b01;
      step();
      bus.fire_valid = 1'b0;
      check_eq("spawn0_we", bus.oam_we, 1);
      check_eq("spawn0_addr", bus.oam_waddr, 0);
      check_eq("spawn0_data", bus.oam_wdata, 32'h3190_6441);
      check_eq("spawn0_mask", active_mask, 8'h01);
      exp_mask[0] = 1'b1;
      tx[0] = 100; ty[0] = 100; td[0] = 1; tow[0] = 1;
      step();
      check_eq("spawn0_idle_we", bus.oam_we, 0);

      // First sweep: slot 0 moves right to x=104, the rest are zeros.
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      step();
      check_eq("sw1_addr0", bus.oam_waddr, 0);
      check_eq("sw1_data0", bus.oam_wdata, 32'h31A0_6441);
      for (int i = 1; i < N; i++) begin
         step();
         check_eq("sw1_zero", bus.oam_wdata, 0);
      end
      tx[0] = 104;
      check_eq("sw1_mask", active_mask, 8'h01);

      // Upward bullet at y=3 leaves the top edge (or wraps to 479).
      fire(200, 3, 0, 2, 1);
      sweep(-1, -1);
`ifdef BULLET_WRAP_EN
      check_eq("edge_mask", active_mask, 8'h03);
`else
      check_eq("edge_mask", active_mask, 8'h01);
`endif

      // Fill every slot, then fire is refused.
      while (exp_mask != 8'hFF) begin
         int s;
         s = 0;
         while (exp_mask[s]) s++;
         fire(40 + 10 * s, 200, 2, s % 4, s);
      end
      check_eq("full_ready", bus.fire_ready, 0);
      bus.fire_valid = 1'b1;
      step();
      bus.fire_valid = 1'b0;
      check_eq("full_no_write", bus.oam_we, 0);

      // Kill slot 5: mask drops at once, zero write follows, slot is reused.
      bus.hit_valid = 1'b1;
      bus.hit_slot  = 3'd5;
      step();
      bus.hit_valid = 1'b0;
      exp_mask[5] = 1'b0;
      check_eq("hit5_mask", active_mask, 8'hDF);
      step();
      check_eq("kill5_we", bus.oam_we, 1);
      check_eq("kill5_addr", bus.oam_waddr, 5);
      check_eq("kill5_data", bus.oam_wdata, 0);
      check_eq("kill5_ready", bus.fire_ready, 1);
      fire(300, 300, 3, 3, 5);

      // Tick mid-sweep raises overrun; hit on the slot being swept zeroes it.
      check_eq("ovr_before", tick_overrun, 0);
      sweep(3, 2);
      check_eq("ovr_after", tick_overrun, 1);

      // Hit on an already dead slot leaves no trace.
      bus.hit_valid = 1'b1;
      bus.hit_slot  = 3'd3;
      step();
      bus.hit_valid = 1'b0;
      check_eq("deadhit_mask", active_mask, exp_mask);
      step();
      check_eq("deadhit_we", bus.oam_we, 0);

      sweep(-1, -1);

      // Reset in the middle of a sweep restarts the clear pass.
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      step();
      check_eq("midrst_we", bus.oam_we, 0);
      check_eq("midrst_mask", active_mask, 0);
      check_eq("midrst_busy", busy, 1);
      check_eq("midrst_overrun", tick_overrun, 0);
      check_eq("midrst_ready", bus.fire_ready, 0);
      rst_n = 1'b1;
      clear_check();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
